matmul_apb_sequencer: RTL and testbench

MATMUL_APB_SEQUENCER -- requirements
Module: matmul_apb_sequencer

---
 rtl/matmul_apb_sequencer.sv | 173 +++++++++++++++++
 tb/tb_matmul_apb_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_apb_sequencer.sv
// Queues APB read/write commands from an accelerator controller and issues them one at a time,
// optionally stalling after a command until the accelerator reports done; read data returns via a FIFO.
module matmul_apb_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int CMD_DEPTH  = 8,
    parameter int RSP_DEPTH  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic                    cmd_write_i,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb_i,
    input  logic                    cmd_wait_done_i,
    input  logic                    done_i,
    output logic                    psel_o,
    output logic                    penable_o,
    output logic                    pwrite_o,
    output logic [ADDR_WIDTH-1:0]   paddr_o,
    output logic [DATA_WIDTH-1:0]   pwdata_o,
    output logic [DATA_WIDTH/8-1:0] pstrb_o,
    input  logic                    pready_i,
    input  logic                    pslverr_i,
    input  logic [DATA_WIDTH-1:0]   prdata_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic                    rsp_err_o,
    output logic                    busy_o,
    output logic                    err_sticky_o,
    input  logic                    clr_err_i,
    output logic [1:0]              dbg_state_o
);
    localparam int SW  = DATA_WIDTH / 8;
    localparam int CAW = $clog2(CMD_DEPTH);
    localparam int RAW = $clog2(RSP_DEPTH);
    localparam logic [CAW:0] CMD_FULL_CNT = CMD_DEPTH[CAW:0];
    localparam logic [CAW:0] CMD_ONE      = {{CAW{1'b0}}, 1'b1};
    localparam logic [RAW:0] RSP_FULL_CNT = RSP_DEPTH[RAW:0];

    typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2, WAIT_DONE = 2'd3} state_t;

    typedef struct packed {
        logic                  write;
        logic                  wait_done;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [SW-1:0]         strb;
    } cmd_t;

    cmd_t                  cmd_mem_q [CMD_DEPTH];
    logic [DATA_WIDTH:0]   rsp_mem_q [RSP_DEPTH];
    logic [CAW:0]          cmd_wr_q, cmd_wr_d, cmd_rd_q, cmd_rd_d;
    logic [RAW:0]          rsp_wr_q, rsp_wr_d, rsp_rd_q, rsp_rd_d;
    state_t                state_q, state_d;
    logic                  err_q, err_d;

    logic [CAW:0]          cmd_count;
    logic [RAW:0]          rsp_count, rsp_count_nxt;
    logic                  cmd_empty, cmd_full, rsp_empty, rsp_full;
    logic                  cmd_push, cmd_pop, rsp_push, rsp_pop, complete;
    logic                  head_elig, next_elig, next_write;
    logic [CAW-1:0]        next_idx;
    cmd_t                  cmd_in, cmd_head;
    logic [DATA_WIDTH:0]   rsp_head;

    assign cmd_count  = cmd_wr_q - cmd_rd_q;
    assign rsp_count  = rsp_wr_q - rsp_rd_q;
    assign cmd_empty  = (cmd_count == '0);
    assign cmd_full   = (cmd_count == CMD_FULL_CNT);
    assign rsp_empty  = (rsp_count == '0);
    assign rsp_full   = (rsp_count == RSP_FULL_CNT);
    assign cmd_head   = cmd_mem_q[cmd_rd_q[CAW-1:0]];
    assign next_idx   = cmd_rd_q[CAW-1:0] + 1'b1;
    assign next_write = cmd_mem_q[next_idx].write;
    assign rsp_head   = rsp_mem_q[rsp_rd_q[RAW-1:0]];

    assign cmd_in = '{write: cmd_write_i, wait_done: cmd_wait_done_i, addr: cmd_addr_i,
                      wdata: cmd_wdata_i, strb: cmd_strb_i};

    assign cmd_ready_o = !cmd_full;
    assign cmd_push    = cmd_valid_i && !cmd_full;
    assign complete    = (state_q == ACCESS) && pready_i;
    assign cmd_pop     = complete;
    assign rsp_push    = complete && !cmd_head.write;
    assign rsp_valid_o = !rsp_empty;
    assign rsp_pop     = rsp_valid_o && rsp_ready_i;

    // A read may only start if its response is guaranteed a slot when it completes.
    assign head_elig = !cmd_empty && (cmd_head.write || !rsp_full);

    always_comb begin
        rsp_count_nxt = rsp_count;
        if (rsp_push) rsp_count_nxt = rsp_count_nxt + 1'b1;
        if (rsp_pop)  rsp_count_nxt = rsp_count_nxt - 1'b1;
    end

    // Back-to-back eligibility looks at the entry behind the head being popped now.
    assign next_elig = (cmd_count > CMD_ONE) && (next_write || (rsp_count_nxt < RSP_FULL_CNT));

    always_comb begin
        cmd_wr_d = cmd_wr_q;
        cmd_rd_d = cmd_rd_q;
        rsp_wr_d = rsp_wr_q;
        rsp_rd_d = rsp_rd_q;
        if (cmd_push) cmd_wr_d = cmd_wr_q + 1'b1;
        if (cmd_pop)  cmd_rd_d = cmd_rd_q + 1'b1;
        if (rsp_push) rsp_wr_d = rsp_wr_q + 1'b1;
        if (rsp_pop)  rsp_rd_d = rsp_rd_q + 1'b1;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (head_elig) state_d = SETUP;
            SETUP:     state_d = ACCESS;
            ACCESS: begin
                if (pready_i) begin
                    if (cmd_head.wait_done) state_d = WAIT_DONE;
                    else if (next_elig)     state_d = SETUP;
                    else                    state_d = IDLE;
                end
            end
            WAIT_DONE: if (done_i) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        err_d = err_q;
        if (clr_err_i)              err_d = 1'b0;
        if (complete && pslverr_i)  err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cmd_wr_q <= '0;
            cmd_rd_q <= '0;
            rsp_wr_q <= '0;
            rsp_rd_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cmd_wr_q <= cmd_wr_d;
            cmd_rd_q <= cmd_rd_d;
            rsp_wr_q <= rsp_wr_d;
            rsp_rd_q <= rsp_rd_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (cmd_push) cmd_mem_q[cmd_wr_q[CAW-1:0]] <= cmd_in;
        if (rsp_push) rsp_mem_q[rsp_wr_q[RAW-1:0]] <= {prdata_i, pslverr_i};
    end

    // Payload is forced to zero outside a transfer, and write-only fields are zero for reads.
    assign psel_o       = (state_q == SETUP) || (state_q == ACCESS);
    assign penable_o    = (state_q == ACCESS);
    assign pwrite_o     = psel_o && cmd_head.write;
    assign paddr_o      = psel_o ? cmd_head.addr : '0;
    assign pwdata_o     = pwrite_o ? cmd_head.wdata : '0;
    assign pstrb_o      = pwrite_o ? cmd_head.strb : '0;
    assign rsp_rdata_o  = rsp_empty ? '0 : rsp_head[DATA_WIDTH:1];
    assign rsp_err_o    = !rsp_empty && rsp_head[0];
    assign busy_o       = !cmd_empty || (state_q != IDLE);
    assign err_sticky_o = err_q;
    assign dbg_state_o  = state_q;
endmodule

// File: tb/tb_matmul_apb_sequencer.sv
// Directed bench for matmul_apb_sequencer: single transfers, wait states, FIFO full,
// wait-for-done sequencing, response back-pressure, error sticky bit and async reset.
module tb_matmul_apb_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic        cmd_write_i = 1'b0;
    logic [15:0] cmd_addr_i = '0;
    logic [31:0] cmd_wdata_i = '0;
    logic [3:0]  cmd_strb_i = '0;
    logic        cmd_wait_done_i = 1'b0;
    logic        done_i = 1'b0;
    logic        psel_o, penable_o, pwrite_o;
    logic [15:0] paddr_o;
    logic [31:0] pwdata_o;
    logic [3:0]  pstrb_o;
    logic        pready_i = 1'b1;
    logic        pslverr_i = 1'b0;
    logic [31:0] prdata_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        busy_o;
    logic        err_sticky_o;
    logic        clr_err_i = 1'b0;
    logic [1:0]  dbg_state_o;

    localparam logic [1:0] S_IDLE = 2'd0, S_SETUP = 2'd1, S_ACCESS = 2'd2, S_WAIT = 2'd3;

    int checks = 0;
    int failures = 0;

    matmul_apb_sequencer dut (
        .clk(clk), .rst(rst),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
        .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i), .cmd_strb_i(cmd_strb_i),
        .cmd_wait_done_i(cmd_wait_done_i), .done_i(done_i),
        .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o), .paddr_o(paddr_o),
        .pwdata_o(pwdata_o), .pstrb_o(pstrb_o), .pready_i(pready_i), .pslverr_i(pslverr_i),
        .prdata_i(prdata_i), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o), .busy_o(busy_o),
        .err_sticky_o(err_sticky_o), .clr_err_i(clr_err_i), .dbg_state_o(dbg_state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic w, input logic [15:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic wt);
        cmd_valid_i = 1'b1;
        cmd_write_i = w;
        cmd_addr_i = a;
        cmd_wdata_i = d;
        cmd_strb_i = s;
        cmd_wait_done_i = wt;
        tick();
        cmd_valid_i = 1'b0;
        cmd_wait_done_i = 1'b0;
    endtask

    initial begin
        // Reset values
        #2;
        check("rst_cmd_ready", cmd_ready_o, 1);
        check("rst_psel", psel_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_rsp_valid", rsp_valid_o, 0);
        check("rst_err", err_sticky_o, 0);
        check("rst_state", dbg_state_o, S_IDLE);
        tick();
        rst = 1'b0;
        tick();

        // Single write, pready tied high
        pready_i = 1'b1;
        push(1'b1, 16'h0000, 32'h1, 4'hF, 1'b0);
        check("w1_idle_after_push", dbg_state_o, S_IDLE);
        check("w1_busy", busy_o, 1);
        tick();
        check("w1_setup_state", dbg_state_o, S_SETUP);
        check("w1_setup_psel", psel_o, 1);
        check("w1_setup_penable", penable_o, 0);
        check("w1_setup_pwrite", pwrite_o, 1);
        check("w1_setup_paddr", paddr_o, 16'h0000);
        check("w1_setup_pwdata", pwdata_o, 32'h1);
        check("w1_setup_pstrb", pstrb_o, 4'hF);
        tick();
        check("w1_access_state", dbg_state_o, S_ACCESS);
        check("w1_access_penable", penable_o, 1);
        check("w1_access_pwdata", pwdata_o, 32'h1);
        tick();
        check("w1_idle_state", dbg_state_o, S_IDLE);
        check("w1_idle_psel", psel_o, 0);
        check("w1_idle_pwrite", pwrite_o, 0);
        check("w1_idle_pwdata", pwdata_o, 0);
        check("w1_idle_pstrb", pstrb_o, 0);
        check("w1_idle_busy", busy_o, 0);

        // Read with three wait states
        pready_i = 1'b0;
        prdata_i = 32'h2A;
        push(1'b0, 16'h0010, 32'hDEAD_BEEF, 4'hF, 1'b0);
        tick();
        check("r1_setup_state", dbg_state_o, S_SETUP);
        check("r1_setup_paddr", paddr_o, 16'h0010);
        check("r1_setup_pwrite", pwrite_o, 0);
        check("r1_setup_pwdata", pwdata_o, 0);
        check("r1_setup_pstrb", pstrb_o, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("r1_access_penable", penable_o, 1);
            check("r1_access_psel", psel_o, 1);
            check("r1_access_paddr", paddr_o, 16'h0010);
            check("r1_access_pstrb", pstrb_o, 0);
            if (i == 3) pready_i = 1'b1;
        end
        tick();
        check("r1_done_state", dbg_state_o, S_IDLE);
        check("r1_done_penable", penable_o, 0);
        check("r1_rsp_valid", rsp_valid_o, 1);
        check("r1_rsp_rdata", rsp_rdata_o, 32'h2A);
        check("r1_rsp_err", rsp_err_o, 0);
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        check("r1_rsp_popped", rsp_valid_o, 0);

        // Fill the command FIFO while the first transfer stalls
        pready_i = 1'b0;
        for (int k = 0; k < 8; k++) begin
            cmd_valid_i = 1'b1;
            cmd_write_i = 1'b1;
            cmd_addr_i = 16'h0100 + 16'(4 * k);
            cmd_wdata_i = 32'hA000 + 32'(k);
            cmd_strb_i = 4'hF;
            tick();
        end
        check("full_cmd_ready", cmd_ready_o, 0);
        cmd_addr_i = 16'h0999;
        tick();
        check("full_ninth_refused", cmd_ready_o, 0);
        cmd_valid_i = 1'b0;
        check("full_head_access", dbg_state_o, S_ACCESS);
        check("full_head_addr", paddr_o, 16'h0100);
        pready_i = 1'b1;
        for (int k = 1; k < 8; k++) begin
            tick();
            check("b2b_setup_state", dbg_state_o, S_SETUP);
            check("b2b_setup_psel", psel_o, 1);
            check("b2b_setup_paddr", paddr_o, 16'h0100 + 16'(4 * k));
            tick();
            check("b2b_access_state", dbg_state_o, S_ACCESS);
            check("b2b_access_psel", psel_o, 1);
            check("b2b_access_pwdata", pwdata_o, 32'hA000 + 32'(k));
        end
        tick();
        check("b2b_end_idle", dbg_state_o, S_IDLE);
        check("b2b_end_busy", busy_o, 0);
        check("b2b_end_ready", cmd_ready_o, 1);

        // Write with wait-for-done, then a read
        prdata_i = 32'h55;
        push(1'b1, 16'h0000, 32'h7, 4'hF, 1'b1);
        push(1'b0, 16'h0020, 32'h0, 4'h0, 1'b0);
        check("wd_setup", dbg_state_o, S_SETUP);
        tick();
        check("wd_access", dbg_state_o, S_ACCESS);
        tick();
        check("wd_wait_state", dbg_state_o, S_WAIT);
        check("wd_wait_psel", psel_o, 0);
        check("wd_wait_paddr", paddr_o, 0);
        for (int i = 0; i < 19; i++) begin
            tick();
            check("wd_still_waiting", dbg_state_o, S_WAIT);
        end
        done_i = 1'b1;
        tick();
        check("wd_done_idle", dbg_state_o, S_IDLE);
        check("wd_done_psel", psel_o, 0);
        tick();
        done_i = 1'b0;
        check("wd_read_setup", dbg_state_o, S_SETUP);
        check("wd_read_paddr", paddr_o, 16'h0020);
        check("wd_read_pwrite", pwrite_o, 0);
        tick();
        tick();
        check("wd_read_idle", dbg_state_o, S_IDLE);
        check("wd_read_rdata", rsp_rdata_o, 32'h55);
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;

        // done_i already high on entering WAIT_DONE
        done_i = 1'b1;
        push(1'b1, 16'h0004, 32'h8, 4'h3, 1'b1);
        tick();
        tick();
        tick();
        check("wdh_wait_state", dbg_state_o, S_WAIT);
        tick();
        check("wdh_idle", dbg_state_o, S_IDLE);
        done_i = 1'b0;

        // Response FIFO back-pressure
        prdata_i = 32'h77;
        for (int k = 0; k < 8; k++) push(1'b0, 16'h0200 + 16'(4 * k), 32'h0, 4'h0, 1'b0);
        for (int i = 0; i < 60; i++) begin
            if (!busy_o) break;
            tick();
        end
        check("bp_drained", busy_o, 0);
        check("bp_rsp_valid", rsp_valid_o, 1);
        push(1'b0, 16'h0300, 32'h0, 4'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_blocked_psel", psel_o, 0);
            check("bp_blocked_busy", busy_o, 1);
        end
        check("bp_head_rdata", rsp_rdata_o, 32'h77);
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        check("bp_pop_idle", dbg_state_o, S_IDLE);
        tick();
        check("bp_read_setup", dbg_state_o, S_SETUP);
        check("bp_read_paddr", paddr_o, 16'h0300);
        tick();
        tick();
        check("bp_read_idle", dbg_state_o, S_IDLE);
        rsp_ready_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check("bp_drain_valid", rsp_valid_o, 1);
            check("bp_drain_rdata", rsp_rdata_o, 32'h77);
            tick();
        end
        rsp_ready_i = 1'b0;
        check("bp_drain_empty", rsp_valid_o, 0);

        // Slave error, sticky clear, set-wins-over-clear
        pslverr_i = 1'b1;
        push(1'b1, 16'h0030, 32'h9, 4'hF, 1'b0);
        tick();
        tick();
        tick();
        check("err_set", err_sticky_o, 1);
        pslverr_i = 1'b0;
        clr_err_i = 1'b1;
        tick();
        clr_err_i = 1'b0;
        check("err_cleared", err_sticky_o, 0);
        push(1'b0, 16'h0034, 32'h0, 4'h0, 1'b0);
        tick();
        tick();
        check("err2_access", dbg_state_o, S_ACCESS);
        clr_err_i = 1'b1;
        pslverr_i = 1'b1;
        tick();
        clr_err_i = 1'b0;
        pslverr_i = 1'b0;
        check("err2_set_wins", err_sticky_o, 1);
        check("err2_rsp_err", rsp_err_o, 1);
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;

        // Asynchronous reset during a stalled ACCESS with a second command queued
        pready_i = 1'b0;
        push(1'b1, 16'h0040, 32'h1, 4'hF, 1'b0);
        push(1'b1, 16'h0044, 32'h2, 4'hF, 1'b0);
        tick();
        check("ar_access", penable_o, 1);
        #2;
        rst = 1'b1;
        #1;
        check("ar_psel_async", psel_o, 0);
        check("ar_penable_async", penable_o, 0);
        check("ar_err_async", err_sticky_o, 0);
        check("ar_busy_async", busy_o, 0);
        check("ar_ready_async", cmd_ready_o, 1);
        check("ar_state_async", dbg_state_o, S_IDLE);
        tick();
        rst = 1'b0;
        pready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ar_discarded_psel", psel_o, 0);
            check("ar_discarded_busy", busy_o, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
